// File: rtl/rddata_collector.sv
// rddata_collector: DDR read return path.
// Pairs PHY read beats into bursts, matches each burst with the tag queued
// when its read was issued, and routes host bursts to a small FWFT output
// FIFO while periodic-read bursts are absorbed and signalled by a pulse.
// Optional build macro RDBACK_CNT_EN adds the rdback_cnt host-burst counter.
//
// Handshake: rdback_valid/rdback_ready follow strict valid/ready semantics;
// a burst leaves the FIFO in any cycle where both are high, rdback_data is
// stable while rdback_valid=1 and rdback_ready=0, and rdback_valid never
// depends combinationally on rdback_ready.
module rddata_collector #(
  parameter int DQ_WIDTH   = 64,
  parameter int TAG_DEPTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_issue,
  input  logic                  rd_issue_periodic,
  input  logic                  dfi_rddata_valid,
  input  logic [4*DQ_WIDTH-1:0] dfi_rddata,
  output logic                  rdback_valid,
  output logic [8*DQ_WIDTH-1:0] rdback_data,
  input  logic                  rdback_ready,
  output logic                  pr_rd_done,
  output logic                  tag_ovf,
  output logic                  data_ovf,
  output logic                  orphan
`ifdef RDBACK_CNT_EN
  ,
  output logic [15:0]           rdback_cnt
`endif
);

  localparam int BEAT_W  = 4 * DQ_WIDTH;
  localparam int BURST_W = 8 * DQ_WIDTH;
  localparam int TPW     = $clog2(TAG_DEPTH);
  localparam int TCW     = TPW + 1;
  localparam int FPW     = $clog2(FIFO_DEPTH);
  localparam int FCW     = FPW + 1;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beat_e;

  // Collector state
  beat_e             state_q;
  logic [BEAT_W-1:0] low_q;

  // Tag queue
  logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
  logic [TPW-1:0]       tag_wr_q, tag_wr_d;
  logic [TPW-1:0]       tag_rd_q, tag_rd_d;
  logic [TCW-1:0]       tag_cnt_q, tag_cnt_d;

  // Output FIFO
  logic [BURST_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [BURST_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [FPW-1:0]     fifo_wr_q, fifo_wr_d;
  logic [FPW-1:0]     fifo_rd_q, fifo_rd_d;
  logic [FCW-1:0]     fifo_cnt_q, fifo_cnt_d;

  // Status flops
  logic pr_rd_done_q, pr_rd_done_d;
  logic tag_ovf_q, tag_ovf_d;
  logic data_ovf_q, data_ovf_d;
  logic orphan_q, orphan_d;
`ifdef RDBACK_CNT_EN
  logic [15:0] rdback_cnt_q, rdback_cnt_d;
`endif

  // Per-cycle decisions
  logic               burst_done;
  logic [BURST_W-1:0] burst;
  logic               tag_empty, tag_full, tag_pop, tag_push, tag_head;
  logic               is_periodic, host_done;
  logic               fifo_full, fifo_pop, fifo_push;

  assign burst_done  = (state_q == BEAT1) && dfi_rddata_valid;
  assign burst       = {dfi_rddata, low_q};

  assign tag_empty   = (tag_cnt_q == '0);
  assign tag_full    = (tag_cnt_q == TCW'(TAG_DEPTH));
  assign tag_head    = tag_mem_q[tag_rd_q];
  assign tag_pop     = burst_done && !tag_empty;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign tag_push    = rd_issue && (!tag_full || tag_pop);
  // An orphan burst has no tag and is handled as a host burst.
  assign is_periodic = tag_pop && tag_head;
  assign host_done   = burst_done && !is_periodic;

  assign fifo_full   = (fifo_cnt_q == FCW'(FIFO_DEPTH));
  assign fifo_pop    = rdback_valid && rdback_ready;
  assign fifo_push   = host_done && (!fifo_full || fifo_pop);

  // Beat collector FSM: low half is captured in BEAT0, burst completes in BEAT1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BEAT0;
      low_q   <= '0;
    end else begin
      case (state_q)
        BEAT0: begin
          if (dfi_rddata_valid) begin
            low_q   <= dfi_rddata;
            state_q <= BEAT1;
          end
        end
        BEAT1: begin
          if (dfi_rddata_valid) state_q <= BEAT0;
        end
        default: state_q <= BEAT0;
      endcase
    end
  end

  // Tag queue next state: circular buffer of 1-bit periodic flags.
  always_comb begin
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    if (tag_push) begin
      tag_mem_d[tag_wr_q] = rd_issue_periodic;
      tag_wr_d            = tag_wr_q + TPW'(1);
    end
    if (tag_pop) tag_rd_d = tag_rd_q + TPW'(1);
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + TCW'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - TCW'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  // Output FIFO next state; a push into a full FIFO reuses the slot being popped.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = burst;
      fifo_wr_d             = fifo_wr_q + FPW'(1);
    end
    if (fifo_pop) fifo_rd_d = fifo_rd_q + FPW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Status next state: completion pulse and sticky error flags.
  always_comb begin
    pr_rd_done_d = is_periodic;
    tag_ovf_d    = tag_ovf_q  | (rd_issue && !tag_push);
    data_ovf_d   = data_ovf_q | (host_done && !fifo_push);
    orphan_d     = orphan_q   | (burst_done && tag_empty);
  end

`ifdef RDBACK_CNT_EN
  // Host-burst counter: counts accepted FIFO pushes, wraps naturally.
  always_comb begin
    rdback_cnt_d = rdback_cnt_q + {15'd0, fifo_push};
  end
`endif

  // State registers for tag queue, FIFO and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mem_q    <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      fifo_mem_q   <= '{default: '0};
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_cnt_q   <= '0;
      pr_rd_done_q <= 1'b0;
      tag_ovf_q    <= 1'b0;
      data_ovf_q   <= 1'b0;
      orphan_q     <= 1'b0;
`ifdef RDBACK_CNT_EN
      rdback_cnt_q <= '0;
`endif
    end else begin
      tag_mem_q    <= tag_mem_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      tag_cnt_q    <= tag_cnt_d;
      fifo_mem_q   <= fifo_mem_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_cnt_q   <= fifo_cnt_d;
      pr_rd_done_q <= pr_rd_done_d;
      tag_ovf_q    <= tag_ovf_d;
      data_ovf_q   <= data_ovf_d;
      orphan_q     <= orphan_d;
`ifdef RDBACK_CNT_EN
      rdback_cnt_q <= rdback_cnt_d;
`endif
    end
  end

  assign rdback_valid = (fifo_cnt_q != '0);
  assign rdback_data  = fifo_mem_q[fifo_rd_q];
  assign pr_rd_done   = pr_rd_done_q;
  assign tag_ovf      = tag_ovf_q;
  assign data_ovf     = data_ovf_q;
  assign orphan       = orphan_q;
`ifdef RDBACK_CNT_EN
  assign rdback_cnt   = rdback_cnt_q;
`endif

endmodule
